// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory bus arbiter.
//               The optional starvation guard is enabled by the macro
//               MEM_ARB_STARVE_GUARD_EN (see mem_bus_arbiter).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   // Identifies which requester owns a bus transaction
   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_e;

   // Instruction fetches always read a full word
   localparam logic [3:0] BE_FULL = 4'hF;

   // Default configuration values
   localparam int MAX_OUTSTANDING_DEFAULT = 2;
   localparam int STARVE_LIMIT_DEFAULT    = 4;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
// ============================================================================
// Module      : mem_arb_id_fifo
// Description : In-order FIFO of requester IDs, one entry per accepted bus
//               transfer. The head names the owner of the next response.
//               The caller never pushes when full nor pops when empty.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = MAX_OUTSTANDING_DEFAULT,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic             pop_i,
   input  req_id_e          wdata_i,
   output req_id_e          head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   req_id_e          mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;

   // Pointers wrap at DEPTH, which need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next occupancy: a simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and registered-full tracking
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (push_i) wptr_q <= ptr_inc(wptr_q);
         if (pop_i)  rptr_q <= ptr_inc(rptr_q);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   // Entry storage; contents are meaningless while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = (count_q == '0);

endmodule : mem_arb_id_fifo

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one req/gnt/rvalid memory bus between the instruction
//               fetch port and the load/store port. Data has fixed priority;
//               a request left waiting for grant is locked until granted.
//               Responses are routed in order via an ID FIFO.
//               Optional macro MEM_ARB_STARVE_GUARD_EN forces the fetch port
//               to win after STARVE_LIMIT consecutive arbitration losses.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
   parameter int STARVE_LIMIT    = STARVE_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   // Instruction fetch port
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   // Load/store port
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   // External memory port
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   // Status
   output logic        unexp_rsp_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic             lock_q;
   logic             lock_d;
   req_id_e          lock_id_q;
   req_id_e          lock_id_d;
   logic             unexp_q;
   req_id_e          w_arb_id;
   req_id_e          w_winner;
   req_id_e          w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // ------------------------------------------------------------------------
   // Unlocked arbitration
   // ------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_q;
   logic            w_starved;
   logic            w_instr_lost;

   assign w_starved = (starve_q == SC_W'(STARVE_LIMIT));

   // Data wins unless the fetch port has already lost STARVE_LIMIT times
   always_comb begin
      w_arb_id = REQ_INSTR;
      if (data_req_i && !(instr_req_i && w_starved)) w_arb_id = REQ_DATA;
   end

   // A loss only counts when an unlocked arbitration actually took place
   assign w_instr_lost = instr_req_i && !lock_q && !w_full && (w_arb_id == REQ_DATA);

   // Consecutive-loss counter for the fetch port, saturating at the limit
   always_ff @(posedge clk) begin
      if (!rstn) begin
         starve_q <= '0;
      end else if (!instr_req_i || instr_gnt_o) begin
         starve_q <= '0;
      end else if (w_instr_lost && !w_starved) begin
         starve_q <= starve_q + SC_W'(1);
      end
   end
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT != 0);

   // Fixed priority: data over instruction
   always_comb begin
      w_arb_id = REQ_INSTR;
      if (data_req_i) w_arb_id = REQ_DATA;
   end
`endif

   // ------------------------------------------------------------------------
   // Request path
   // ------------------------------------------------------------------------
   assign w_winner  = lock_q ? lock_id_q : w_arb_id;

   // Full is registered, so a same-cycle response cannot re-open the request
   assign mem_req_o = (lock_q || instr_req_i || data_req_i) && !w_full;

   // Route the winner's transfer attributes onto the bus
   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = BE_FULL;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = '0;
      if (w_winner == REQ_DATA) begin
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_addr_o  = data_addr_i;
         mem_wdata_o = data_wdata_i;
      end
   end

   assign instr_gnt_o = mem_gnt_i && mem_req_o && (w_winner == REQ_INSTR);
   assign data_gnt_o  = mem_gnt_i && mem_req_o && (w_winner == REQ_DATA);

   // Hold the selection while the bus has not yet granted it
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (mem_req_o && !mem_gnt_i) begin
         lock_d    = 1'b1;
         lock_id_d = w_winner;
      end else if (mem_gnt_i) begin
         lock_d    = 1'b0;
      end
   end

   // Lock state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         lock_q    <= 1'b0;
         lock_id_q <= REQ_INSTR;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outstanding transaction tracking and response routing
   // ------------------------------------------------------------------------
   assign w_push = mem_req_o && mem_gnt_i;
   assign w_pop  = mem_rvalid_i && (w_count != '0);

   mem_arb_id_fifo #(
      .DEPTH   (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i (w_winner),
      .head_o  (w_head),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign instr_rvalid_o = w_pop && (w_head == REQ_INSTR);
   assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
   assign instr_err_o    = instr_rvalid_o && mem_err_i;
   assign data_rvalid_o  = w_pop && (w_head == REQ_DATA);
   assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
   assign data_err_o     = data_rvalid_o && mem_err_i;

   // Sticky flag for a response that no transaction was waiting for
   always_ff @(posedge clk) begin
      if (!rstn) begin
         unexp_q <= 1'b0;
      end else if (mem_rvalid_i && w_empty) begin
         unexp_q <= 1'b1;
      end
   end

   assign unexp_rsp_o = unexp_q;

endmodule : mem_bus_arbiter

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter
//               (MAX_OUTSTANDING=2, STARVE_LIMIT=4). Expected starvation
//               behaviour follows MEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

   logic        clk;
   logic        rstn;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;
   logic        unexp_rsp_o;

   int vec_cnt;
   int err_cnt;

   mem_bus_arbiter #(
      .MAX_OUTSTANDING (2),
      .STARVE_LIMIT    (4)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .instr_err_o    (instr_err_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .mem_err_i      (mem_err_i),
      .unexp_rsp_o    (unexp_rsp_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // A port whose request is left waiting for grant must keep requesting
   logic r_wait_valid;
   logic r_wait_data;
   always @(negedge clk) begin
      if (!rstn) begin
         r_wait_valid = 1'b0;
      end else begin
         if (r_wait_valid) begin
            assert (r_wait_data ? data_req_i : instr_req_i) else begin
               err_cnt++;
               $error("FAIL protocol_hold: locked req observed 0 expected 1");
            end
         end
         r_wait_valid = mem_req_o && !mem_gnt_i;
         r_wait_data  = data_req_i && (mem_addr_o == data_addr_i);
      end
   end

   initial begin
      logic exp_i;
      vec_cnt      = 0;
      err_cnt      = 0;
      rstn         = 1'b0;
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      #2;
      chk1 ("rst_mem_req",   mem_req_o,      1'b0);
      chk1 ("rst_instr_gnt", instr_gnt_o,    1'b0);
      chk1 ("rst_data_gnt",  data_gnt_o,     1'b0);
      chk1 ("rst_i_rvalid",  instr_rvalid_o, 1'b0);
      chk1 ("rst_d_rvalid",  data_rvalid_o,  1'b0);
      chk1 ("rst_unexp",     unexp_rsp_o,    1'b0);
      chk32("rst_count",     32'(dut.w_count), 32'd0);
      tick();
      rstn = 1'b1;

      // ---------------- single fetch ----------------
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0100;
      mem_gnt_i    = 1'b1;
      #2;
      chk1 ("f1_mem_req",   mem_req_o,   1'b1);
      chk32("f1_mem_addr",  mem_addr_o,  32'h0000_0100);
      chk32("f1_mem_be",    32'(mem_be_o), 32'hF);
      chk1 ("f1_mem_we",    mem_we_o,    1'b0);
      chk32("f1_mem_wdata", mem_wdata_o, 32'h0);
      chk1 ("f1_instr_gnt", instr_gnt_o, 1'b1);
      chk1 ("f1_data_gnt",  data_gnt_o,  1'b0);
      tick();
      instr_req_i  = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      #2;
      chk1 ("f1_gnt_pulse",  instr_gnt_o,    1'b0);
      chk32("f1_count",      32'(dut.w_count), 32'd1);
      chk1 ("f1_i_rvalid",   instr_rvalid_o, 1'b1);
      chk32("f1_i_rdata",    instr_rdata_o,  32'hDEAD_BEEF);
      chk1 ("f1_d_rvalid",   data_rvalid_o,  1'b0);
      chk32("f1_d_rdata",    data_rdata_o,   32'h0);
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      chk32("f1_count_end",  32'(dut.w_count), 32'd0);

      // ---------------- both ports request ----------------
      tick();
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'h3;
      data_addr_i  = 32'h0000_0200;
      data_wdata_i = 32'h1234_5678;
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0104;
      mem_gnt_i    = 1'b1;
      #2;
      chk32("b_mem_addr_d", mem_addr_o,  32'h0000_0200);
      chk1 ("b_mem_we_d",   mem_we_o,    1'b1);
      chk32("b_mem_be_d",   32'(mem_be_o), 32'h3);
      chk32("b_wdata_d",    mem_wdata_o, 32'h1234_5678);
      chk1 ("b_data_gnt",   data_gnt_o,  1'b1);
      chk1 ("b_instr_wait", instr_gnt_o, 1'b0);
      tick();
      data_req_i = 1'b0;
      #2;
      chk32("b_mem_addr_i", mem_addr_o,  32'h0000_0104);
      chk1 ("b_mem_we_i",   mem_we_o,    1'b0);
      chk1 ("b_instr_gnt",  instr_gnt_o, 1'b1);
      chk1 ("b_data_idle",  data_gnt_o,  1'b0);
      tick();
      instr_req_i  = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hAAAA_0001;
      mem_err_i    = 1'b1;
      #2;
      chk32("b_count_full", 32'(dut.w_count), 32'd2);
      chk1 ("b_rsp1_d_rv",  data_rvalid_o,  1'b1);
      chk1 ("b_rsp1_d_err", data_err_o,     1'b1);
      chk32("b_rsp1_d_dat", data_rdata_o,   32'hAAAA_0001);
      chk1 ("b_rsp1_i_rv",  instr_rvalid_o, 1'b0);
      chk1 ("b_rsp1_i_err", instr_err_o,    1'b0);
      tick();
      mem_rdata_i = 32'hBBBB_0002;
      mem_err_i   = 1'b0;
      #2;
      chk1 ("b_rsp2_i_rv",  instr_rvalid_o, 1'b1);
      chk32("b_rsp2_i_dat", instr_rdata_o,  32'hBBBB_0002);
      chk1 ("b_rsp2_d_rv",  data_rvalid_o,  1'b0);
      tick();
      mem_rvalid_i = 1'b0;

      // ---------------- lock while waiting for grant ----------------
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0300;
      #2;
      chk32("l_c1_addr", mem_addr_o, 32'h0000_0300);
      tick();
      data_req_i   = 1'b1;
      data_we_i    = 1'b0;
      data_be_i    = 4'hF;
      data_addr_i  = 32'h0000_0400;
      #2;
      chk32("l_c2_addr",  mem_addr_o, 32'h0000_0300);
      chk1 ("l_c2_dgnt",  data_gnt_o, 1'b0);
      tick();
      #2;
      chk32("l_c3_addr",  mem_addr_o, 32'h0000_0300);
      tick();
      mem_gnt_i = 1'b1;
      #2;
      chk1 ("l_gnt_i",    instr_gnt_o, 1'b1);
      chk1 ("l_gnt_d0",   data_gnt_o,  1'b0);
      chk32("l_gnt_addr", mem_addr_o,  32'h0000_0300);
      tick();
      instr_req_i = 1'b0;
      #2;
      chk32("l_d_addr",   mem_addr_o, 32'h0000_0400);
      chk1 ("l_d_gnt",    data_gnt_o, 1'b1);
      tick();
      data_req_i   = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0000_0011;
      #2;
      chk1 ("l_rsp1_i",   instr_rvalid_o, 1'b1);
      tick();
      mem_rdata_i = 32'h0000_0022;
      #2;
      chk1 ("l_rsp2_d",   data_rvalid_o, 1'b1);
      chk32("l_rsp2_dat", data_rdata_o,  32'h0000_0022);
      tick();
      mem_rvalid_i = 1'b0;

      // ---------------- outstanding limit ----------------
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0500;
      mem_gnt_i    = 1'b1;
      #2;
      chk1 ("o_gnt1", instr_gnt_o, 1'b1);
      tick();
      instr_addr_i = 32'h0000_0504;
      #2;
      chk1 ("o_gnt2", instr_gnt_o, 1'b1);
      tick();
      instr_addr_i = 32'h0000_0508;
      #2;
      chk1 ("o_full_req", mem_req_o,   1'b0);
      chk1 ("o_full_gnt", instr_gnt_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b1;
      #2;
      chk1 ("o_rsp_req",  mem_req_o,      1'b0);
      chk1 ("o_rsp_rv",   instr_rvalid_o, 1'b1);
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      chk1 ("o_reopen",   mem_req_o,   1'b1);
      chk1 ("o_gnt3",     instr_gnt_o, 1'b1);
      chk32("o_addr3",    mem_addr_o,  32'h0000_0508);
      tick();
      instr_req_i  = 1'b0;
      mem_rvalid_i = 1'b1;
      tick();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_050C;
      #2;
      chk32("o_cnt1",     32'(dut.w_count), 32'd1);
      chk1 ("o_pp_gnt",   instr_gnt_o,    1'b1);
      chk1 ("o_pp_rv",    instr_rvalid_o, 1'b1);
      tick();
      instr_req_i = 1'b0;
      #2;
      chk32("o_pp_cnt",   32'(dut.w_count), 32'd1);
      tick();
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
      #2;
      chk32("o_drained",  32'(dut.w_count), 32'd0);

      // ---------------- unexpected response and reset ----------------
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0000_0055;
      #2;
      chk1 ("u_i_rv",   instr_rvalid_o, 1'b0);
      chk1 ("u_d_rv",   data_rvalid_o,  1'b0);
      chk32("u_i_dat",  instr_rdata_o,  32'h0);
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      chk1 ("u_set",    unexp_rsp_o, 1'b1);
      tick();
      instr_req_i = 1'b1;
      mem_gnt_i   = 1'b1;
      #2;
      chk1 ("u_hold",   unexp_rsp_o, 1'b1);
      tick();
      instr_req_i = 1'b0;
      mem_gnt_i   = 1'b0;
      rstn        = 1'b0;
      tick();
      rstn = 1'b1;
      #2;
      chk1 ("u_rst_flag",  unexp_rsp_o, 1'b0);
      chk32("u_rst_count", 32'(dut.w_count), 32'd0);
      tick();
      mem_rvalid_i = 1'b1;
      #2;
      chk1 ("u_late_rv",   instr_rvalid_o, 1'b0);
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      chk1 ("u_late_flag", unexp_rsp_o, 1'b1);
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;

      // ---------------- continuous contention ----------------
      tick();
      data_req_i   = 1'b1;
      data_we_i    = 1'b0;
      data_be_i    = 4'hF;
      data_addr_i  = 32'h0000_0600;
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0700;
      mem_gnt_i    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_rvalid_i = (i != 0);
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_i = (i == 4);
`else
         exp_i = 1'b0;
`endif
         #2;
         chk1($sformatf("s_igt%0d", i), instr_gnt_o, exp_i);
         chk1($sformatf("s_dgt%0d", i), data_gnt_o,  !exp_i);
         tick();
      end
      data_req_i   = 1'b0;
      instr_req_i  = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      #2;
      chk32("s_count",  32'(dut.w_count), 32'd1);
      chk1 ("s_last_d", data_rvalid_o, 1'b1);
      tick();
      mem_rvalid_i = 1'b0;
      #2;
      chk32("s_empty",  32'(dut.w_count), 32'd0);
      chk1 ("s_unexp",  unexp_rsp_o, 1'b0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_mem_bus_arbiter

`default_nettype wire
